iic_slave: RTL and testbench

IIC_SLAVE -- requirements
Module: iic_slave

---
 rtl/iic_pkg.sv | 19 +
 rtl/iic_bus_sync.sv | 42 ++++
 rtl/iic_slave.sv | 172 +++++++++++++++++
 tb/tb_iic_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared I2C definitions: slave FSM state encoding and bus ACK/NACK levels.
package iic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } iic_state_t;

  localparam logic BIT_ACK  = 1'b0;
  localparam logic BIT_NACK = 1'b1;

endpackage

// File: rtl/iic_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module iic_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_h;
  logic       sda_h;
  logic       scl_s;

  // Idle bus level is high, so resetting to 1 avoids phantom edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_h    <= scl_sync[1];
      sda_h    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop     = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/iic_slave.sv
// I2C slave exposing an 8-bit register pointer with auto-increment on a simple
// wr_en/rd_req register-file interface.
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iic_scl,
  inout  wire        iic_sda,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  // state     | meaning
  // IDLE      | not addressed, waiting for START
  // ADDR      | shifting in address + R/W
  // ADDR_ACK  | driving address ACK (cnt 8: before ACK clock, 9: during it)
  // PTR       | shifting in register pointer
  // PTR_ACK   | driving pointer ACK
  // WDATA     | shifting in write data
  // WDATA_ACK | driving data ACK, pointer increments at its end
  // RDATA     | shifting out read data
  // RDATA_ACK | sampling master ACK/NACK

  iic_state_t state;
  logic [3:0] cnt;
  logic [7:0] sr;
  logic [7:0] rx_byte;
  logic       rw;
  logic       sda_drv;
  logic       rd_dly;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  iic_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (iic_scl),
    .sda      (iic_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign iic_sda = sda_drv ? 1'b0 : 1'bz;
  assign rx_byte = {sr[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sr       <= 8'h00;
      rw       <= 1'b0;
      sda_drv  <= 1'b0;
      rd_dly   <= 1'b0;
      reg_addr <= 8'h00;
      wr_data  <= 8'h00;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      rd_req <= 1'b0;
      rd_dly <= rd_req;
      if (start) begin
        state   <= ADDR;
        cnt     <= 4'd0;
        sda_drv <= 1'b0;
      end else if (stop) begin
        state   <= IDLE;
        cnt     <= 4'd0;
        sda_drv <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sr  <= rx_byte;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (state == ADDR) begin
                  if (sr[6:0] == SLAVE_ADDR) begin
                    rw    <= sda_s;
                    busy  <= 1'b1;
                    state <= ADDR_ACK;
                  end else begin
                    state <= IDLE;
                  end
                end else if (state == PTR) begin
                  reg_addr <= rx_byte;
                  state    <= PTR_ACK;
                end else begin
                  wr_data <= rx_byte;
                  wr_en   <= 1'b1;
                  state   <= WDATA_ACK;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_rise && state == ADDR_ACK && cnt == 4'd9 && rw) rd_req <= 1'b1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_drv <= ~BIT_ACK;
                cnt     <= 4'd9;
              end else begin
                cnt     <= 4'd0;
                sda_drv <= 1'b0;
                if (state == ADDR_ACK) begin
                  if (rw) begin
                    sda_drv <= ~sr[7];
                    state   <= RDATA;
                  end else begin
                    state <= PTR;
                  end
                end else begin
                  if (state == WDATA_ACK) reg_addr <= reg_addr + 8'd1;
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_drv <= 1'b0;
                state   <= RDATA_ACK;
              end else begin
                sr      <= {sr[6:0], 1'b0};
                sda_drv <= ~sr[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s == BIT_NACK) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= 4'd0;
              end else begin
                reg_addr <= reg_addr + 8'd1;
                rd_req   <= 1'b1;
                cnt      <= 4'd9;
              end
            end else if (scl_fall && cnt == 4'd9) begin
              cnt     <= 4'd0;
              sda_drv <= ~sr[7];
              state   <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
      // Register file returns data two clocks after the request.
      if (rd_dly) sr <= rd_data;
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// Directed bus-level bench for iic_slave acting as the I2C master.
`timescale 1ns/1ps
module tb_iic_slave;
  import iic_pkg::*;

  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        iic_sda;
  logic [7:0] reg_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       busy;

  int n_assert = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];

  always #10 clk = ~clk;

  assign iic_sda = m_sda ? 1'bz : 1'b0;
  pullup (iic_sda);
  assign rd_data = reg_addr + 8'h30;

  iic_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iic_scl  (scl),
    .iic_sda  (iic_sda),
    .reg_addr (reg_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      wr_a.push_back(reg_addr);
      wr_d.push_back(wr_data);
    end
    if (rd_req) rd_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; scl = 1'b1; #T;
    m_sda = 1'b0; #T;
    scl = 1'b0; #T;
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; #T;
    scl = 1'b1; #T;
    m_sda = 1'b0; #T;
    scl = 1'b0; #T;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #T;
    scl = 1'b1; #T;
    m_sda = 1'b1; #T;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; #T;
    scl = 1'b1; #(T/2);
    s = iic_sda; #(T/2);
    scl = 1'b0; #T;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(mack, s);
    m_sda = 1'b1;
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rb;
    int         wb;
    int         rbase;

    #100;
    check("rst_sda", iic_sda, 1'b1);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1; #T;

    // Single-byte write
    wb = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", ack, BIT_ACK);
    write_byte(8'h10, ack); check("wr_ptr_ack", ack, BIT_ACK);
    check("wr_busy", busy, 1'b1);
    write_byte(8'h5A, ack); check("wr_data_ack", ack, BIT_ACK);
    bus_stop();
    check("wr_count", wr_cnt - wb, 1);
    check("wr_at_addr", wr_a[wb], 8'h10);
    check("wr_at_data", wr_d[wb], 8'h5A);
    check("wr_final_ptr", reg_addr, 8'h11);
    check("wr_busy_stop", busy, 1'b0);

    // Pointer write, repeated START, two-byte read
    rbase = rd_cnt;
    bus_start();
    write_byte(8'hA0, ack); check("rd_addr_ack", ack, BIT_ACK);
    write_byte(8'h20, ack); check("rd_ptr_ack", ack, BIT_ACK);
    bus_rstart();
    write_byte(8'hA1, ack); check("rd_addr_r_ack", ack, BIT_ACK);
    read_byte(BIT_ACK, rb);  check("rd_byte0", rb, 8'h50);
    read_byte(BIT_NACK, rb); check("rd_byte1", rb, 8'h51);
    check("rd_busy_nack", busy, 1'b0);
    check("rd_ptr", reg_addr, 8'h21);
    check("rd_req_count", rd_cnt - rbase, 2);
    bus_stop();

    // Foreign address
    wb = wr_cnt; rbase = rd_cnt;
    bus_start();
    write_byte(8'hA2, ack); check("miss_nack", ack, BIT_NACK);
    check("miss_busy", busy, 1'b0);
    bus_stop();
    check("miss_wr", wr_cnt - wb, 0);
    check("miss_rd", rd_cnt - rbase, 0);
    check("miss_ptr", reg_addr, 8'h21);

    // Pointer wrap
    wb = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); check("wrap_ack0", ack, BIT_ACK);
    write_byte(8'h22, ack); check("wrap_ack1", ack, BIT_ACK);
    bus_stop();
    check("wrap_count", wr_cnt - wb, 2);
    check("wrap_addr0", wr_a[wb], 8'hFF);
    check("wrap_addr1", wr_a[wb + 1], 8'h00);
    check("wrap_data1", wr_d[wb + 1], 8'h22);
    check("wrap_ptr", reg_addr, 8'h01);

    // STOP during the 4th data bit
    wb = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
    m_sda = 1'b0; #T;
    scl = 1'b1; #(T/2);
    m_sda = 1'b1; #T;
    check("abort_busy", busy, 1'b0);
    check("abort_wr", wr_cnt - wb, 0);
    check("abort_sda", iic_sda, 1'b1);
    check("abort_ptr", reg_addr, 8'h10);

    // Reset while the slave holds the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(((8'hA0 >> i) & 8'h01) != 8'h00, s);
    m_sda = 1'b1; #T;
    check("ack_driven", iic_sda, 1'b0);
    rst_n = 1'b0; #1;
    check("rst_mid_sda", iic_sda, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ptr", reg_addr, 8'h00);
    #T; scl = 1'b1; #T;
    rst_n = 1'b1; #T;
    wb = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack); check("post_rst_addr_ack", ack, BIT_ACK);
    write_byte(8'h05, ack);
    write_byte(8'h77, ack); check("post_rst_data_ack", ack, BIT_ACK);
    bus_stop();
    check("post_rst_count", wr_cnt - wb, 1);
    check("post_rst_addr", wr_a[wb], 8'h05);
    check("post_rst_data", wr_d[wb], 8'h77);
    check("post_rst_ptr", reg_addr, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
